// File: rtl/det_share_ctrl.sv
// -----------------------------------------------------------------------------
// det_share_ctrl
//
// Round-robin controller that time-shares one serial sequence-detector FSM
// among NREQ requesters. A granted requester's WIDTH-bit word is shifted into
// the detector MSB first, right after a one-cycle detector clear. The cycles
// where the detector asserts Z are counted, and the count is returned with the
// requester ID.
//
// Optional feature: define DET_FIRSTPOS_EN to add the first_pos output. It
// reports the bit index of the first counted match, or all-ones if there was
// no match.
//
// Ports:
//   Clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   [NREQ]        request levels, held until granted
//   data       in   [NREQ*WIDTH]  request words, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  [NREQ]        one-hot grant pulse; data[i] captured on that edge
//   busy       out  high from the grant edge through the DONE cycle
//   det_X      out  serial bit to the detector
//   det_reset  out  detector reset (active-high)
//   det_Z      in   detector output
//   done       out  one-cycle result-valid pulse
//   done_id    out  [$clog2(NREQ)] ID of the finished requester (held)
//   match_cnt  out  [CNTW]        number of counted det_Z=1 samples (held)
//   first_pos  out  [$clog2(WIDTH)+1] first match index (DET_FIRSTPOS_EN only)
//   dbg_state  out  [3]           current FSM state, for debug/checkers
//
// Handshake: a request is a level on req[i]. It is consumed on the rising edge
// where gnt[i]=1. Requests seen while busy are not queued. Results are valid in
// the cycle where done=1 and stay on done_id/match_cnt until the next done.
// -----------------------------------------------------------------------------
module det_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CNTW  = 4,
    parameter int LAT   = 0
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      det_X,
    output logic                      det_reset,
    input  logic                      det_Z,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [CNTW-1:0]           match_cnt,
`ifdef DET_FIRSTPOS_EN
    output logic [$clog2(WIDTH):0]    first_pos,
`endif
    output logic [2:0]                dbg_state
);

    localparam int IDW = $clog2(NREQ);
    localparam int FPW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [FPW-1:0]     bit_q, bit_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [CNTW-1:0]    match_q, match_d;
`ifdef DET_FIRSTPOS_EN
    logic [FPW-1:0]     fp_run_q, fp_run_d;
    logic [FPW-1:0]     fp_q, fp_d;
    logic [FPW-1:0]     resp_idx;
`endif

    logic               gnt_hit;
    logic [IDW-1:0]     gnt_idx;
    logic               sample_en;
    logic               hit;

    // Round-robin search: first set req bit starting at rr_q, wrapping.
    always_comb begin
        int k;
        k       = 0;
        gnt_hit = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(rr_q) + i) % NREQ;
            if (!gnt_hit && req[k]) begin
                gnt_hit = 1'b1;
                gnt_idx = IDW'(k);
            end
        end
    end

    // With a registered detector (LAT=1), the first SHIFT sample still shows
    // the cleared state, so it is skipped. The response to the last bit then
    // arrives in DRAIN.
    assign sample_en = ((state_q == S_SHIFT) && ((LAT == 0) || (bit_q != '0)))
                     || (state_q == S_DRAIN);
    assign hit       = sample_en && det_Z;

`ifdef DET_FIRSTPOS_EN
    // Bit index of the word that the current sample responds to.
    assign resp_idx = (state_q == S_DRAIN) ? FPW'(WIDTH - 1)
                                           : (bit_q - FPW'(LAT));
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        done_id_d = done_id_q;
        match_d   = match_q;
`ifdef DET_FIRSTPOS_EN
        fp_run_d  = fp_run_q;
        fp_d      = fp_q;
`endif
        gnt       = '0;
        det_X     = 1'b0;
        done      = 1'b0;

        // Saturating match counter.
        if (hit && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
`ifdef DET_FIRSTPOS_EN
        // A zero count means this is the first counted match.
        if (hit && (cnt_q == '0)) begin
            fp_run_d = resp_idx;
        end
`endif

        case (state_q)
            S_IDLE: begin
                // Gated by reset so that no grant pulse appears while reset is held.
                if (gnt_hit && !reset) begin
                    gnt[gnt_idx] = 1'b1;
                    sh_d         = data[gnt_idx*WIDTH +: WIDTH];
                    id_d         = gnt_idx;
                    cnt_d        = '0;
                    bit_d        = '0;
                    rr_d         = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef DET_FIRSTPOS_EN
                    fp_run_d     = '1;
`endif
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                det_X = sh_q[WIDTH-1];
                sh_d  = sh_q << 1;
                bit_d = bit_q + 1'b1;
                if (bit_q == FPW'(WIDTH - 1)) begin
                    state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are loaded on the edge that enters DONE. They are then
        // already valid during the done pulse, and the final sample is
        // included through cnt_d.
        if (state_d == S_DONE) begin
            match_d   = cnt_d;
            done_id_d = id_d;
`ifdef DET_FIRSTPOS_EN
            fp_d      = fp_run_d;
`endif
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            done_id_q <= '0;
            match_q   <= '0;
`ifdef DET_FIRSTPOS_EN
            fp_run_q  <= '0;
            fp_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            done_id_q <= done_id_d;
            match_q   <= match_d;
`ifdef DET_FIRSTPOS_EN
            fp_run_q  <= fp_run_d;
            fp_q      <= fp_d;
`endif
        end
    end

    // Controller reset propagates to the detector asynchronously.
    assign det_reset = reset | (state_q == S_CLR);
    assign busy      = (state_q != S_IDLE);
    assign done_id   = done_id_q;
    assign match_cnt = match_q;
    assign dbg_state = state_q;
`ifdef DET_FIRSTPOS_EN
    assign first_pos = fp_q;
`endif

endmodule

// File: tb/tb_det_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_det_share_ctrl
//
// Two instances of det_share_ctrl:
//   u=0 : defaults (WIDTH=8, NREQ=2, CNTW=4, LAT=0), with Mealy echo stub Z=X
//   u=1 : LAT=1, CNTW=3, with a registered stub (Z = X delayed one cycle,
//         cleared by det_reset)
// A transaction-level model predicts every output on every cycle. Directed
// transactions also pin literal results.
// -----------------------------------------------------------------------------
module tb_det_share_ctrl;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]  req0 = '0, req1 = '0;
    logic [15:0] data0 = '0, data1 = '0;
    logic [1:0]  gnt0, gnt1;
    logic        busy0, busy1, x0, x1, dr0, dr1, done0, done1;
    logic        z0, z1;
    logic        id0, id1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  dbg0, dbg1;
`ifdef DET_FIRSTPOS_EN
    logic [3:0]  fp0, fp1;
`endif

    det_share_ctrl #(.WIDTH(8), .NREQ(2), .CNTW(4), .LAT(0)) dut0 (
        .Clk(clk), .reset(rst), .req(req0), .data(data0), .gnt(gnt0),
        .busy(busy0), .det_X(x0), .det_reset(dr0), .det_Z(z0), .done(done0),
        .done_id(id0), .match_cnt(cnt0),
`ifdef DET_FIRSTPOS_EN
        .first_pos(fp0),
`endif
        .dbg_state(dbg0)
    );

    det_share_ctrl #(.WIDTH(8), .NREQ(2), .CNTW(3), .LAT(1)) dut1 (
        .Clk(clk), .reset(rst), .req(req1), .data(data1), .gnt(gnt1),
        .busy(busy1), .det_X(x1), .det_reset(dr1), .det_Z(z1), .done(done1),
        .done_id(id1), .match_cnt(cnt1),
`ifdef DET_FIRSTPOS_EN
        .first_pos(fp1),
`endif
        .dbg_state(dbg1)
    );

    // Detector stubs
    assign z0 = x0;
    always_ff @(posedge clk or posedge dr1) begin
        if (dr1) z1 <= 1'b0;
        else     z1 <= x1;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy[2], m_t[2], m_id[2], m_rr[2], m_lid[2], m_lcnt[2];
    logic [7:0] m_word[2];
`ifdef DET_FIRSTPOS_EN
    int         m_lfp[2];
`endif

    function automatic int arb(input logic [1:0] r, input int rr);
        for (int i = 0; i < 2; i++) begin
            if (r[(rr + i) % 2]) return (rr + i) % 2;
        end
        return -1;
    endfunction

    function automatic int first_one(input logic [7:0] wd);
        for (int j = 0; j < W; j++) begin
            if (wd[W-1-j]) return j;
        end
        return 15;
    endfunction

    task automatic check_unit(input int u, input logic [1:0] r, input logic [15:0] d,
                              input logic [1:0] g, input logic b, input logic x,
                              input logic dr, input logic dn, input int id, input int cnt);
        int k, t, lat, cmax, pc, ex_x, ex_dn;
        string p;
        lat  = (u == 0) ? 0 : 1;
        cmax = (u == 0) ? 15 : 7;
        p    = (u == 0) ? "u0" : "u1";
        if (rst) begin
            m_busy[u] = 0; m_rr[u] = 0; m_lid[u] = 0; m_lcnt[u] = 0;
`ifdef DET_FIRSTPOS_EN
            m_lfp[u] = 0;
`endif
            chk({p, "_rst_gnt"}, int'(g), 0);
            chk({p, "_rst_busy"}, int'(b), 0);
            chk({p, "_rst_detx"}, int'(x), 0);
            chk({p, "_rst_detreset"}, int'(dr), 1);
            chk({p, "_rst_done"}, int'(dn), 0);
            chk({p, "_rst_id"}, id, 0);
            chk({p, "_rst_cnt"}, cnt, 0);
        end else if (m_busy[u] == 0) begin
            k = arb(r, m_rr[u]);
            chk({p, "_idle_gnt"}, int'(g), (k < 0) ? 0 : (1 << k));
            chk({p, "_idle_busy"}, int'(b), 0);
            chk({p, "_idle_detx"}, int'(x), 0);
            chk({p, "_idle_detreset"}, int'(dr), 0);
            chk({p, "_idle_done"}, int'(dn), 0);
            chk({p, "_hold_id"}, id, m_lid[u]);
            chk({p, "_hold_cnt"}, cnt, m_lcnt[u]);
            if (k >= 0) begin
                m_busy[u] = 1;
                m_t[u]    = 0;
                m_id[u]   = k;
                m_word[u] = d[k*W +: W];
                m_rr[u]   = (k + 1) % 2;
            end
        end else begin
            m_t[u]++;
            t     = m_t[u];
            ex_x  = (t >= 2 && t <= W + 1) ? int'(m_word[u][W-1-(t-2)]) : 0;
            ex_dn = (t == W + 2 + lat) ? 1 : 0;
            if (ex_dn != 0) begin
                pc        = $countones(m_word[u]);
                m_lid[u]  = m_id[u];
                m_lcnt[u] = (pc > cmax) ? cmax : pc;
`ifdef DET_FIRSTPOS_EN
                m_lfp[u]  = first_one(m_word[u]);
`endif
            end
            chk({p, "_busy_gnt"}, int'(g), 0);
            chk({p, "_busy_busy"}, int'(b), 1);
            chk({p, "_busy_detreset"}, int'(dr), (t == 1) ? 1 : 0);
            chk({p, "_busy_detx"}, int'(x), ex_x);
            chk({p, "_busy_done"}, int'(dn), ex_dn);
            chk({p, "_id"}, id, m_lid[u]);
            chk({p, "_cnt"}, cnt, m_lcnt[u]);
            if (ex_dn != 0) m_busy[u] = 0;
        end
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        check_unit(0, req0, data0, gnt0, busy0, x0, dr0, done0, int'(id0), int'(cnt0));
        check_unit(1, req1, data1, gnt1, busy1, x1, dr1, done1, int'(id1), int'(cnt1));
`ifdef DET_FIRSTPOS_EN
        chk("u0_first_pos", int'(fp0), m_lfp[0]);
        chk("u1_first_pos", int'(fp1), m_lfp[1]);
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int u, input logic [1:0] r, input logic [15:0] d);
        if (u == 0) begin req0 = r; data0 = d; end
        else        begin req1 = r; data1 = d; end
    endtask

    function automatic logic [1:0] get_gnt(input int u);
        return (u == 0) ? gnt0 : gnt1;
    endfunction
    function automatic logic get_done(input int u);
        return (u == 0) ? done0 : done1;
    endfunction
    function automatic logic get_x(input int u);
        return (u == 0) ? x0 : x1;
    endfunction
    function automatic int get_id(input int u);
        return (u == 0) ? int'(id0) : int'(id1);
    endfunction
    function automatic int get_cnt(input int u);
        return (u == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // One transaction with literal expectations: grant, latency, det_X
    // sequence, ID and count.
    task automatic do_txn(input int u, input logic [1:0] r, input logic [15:0] d,
                          input int exp_id, input int exp_cnt, input int exp_lat,
                          input logic [7:0] exp_seq);
        bit ok;
        int n;
        logic [7:0] seq;
        seq = '0;
        @(posedge clk); #2;
        drive(u, r, d);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (get_gnt(u) != 2'b00) begin ok = 1; break; end
        end
        chk("txn_grant_seen", int'(ok), 1);
        @(posedge clk); #2;
        drive(u, 2'b00, d);
        n = 0;
        ok = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= W + 1) seq[W-1-(i-2)] = get_x(u);
            if (get_done(u)) begin n = i; ok = 1; break; end
        end
        chk("txn_done_seen", int'(ok), 1);
        chk("txn_latency", n, exp_lat);
        chk("txn_detx_seq", int'(seq), int'(exp_seq));
        chk("txn_done_id", get_id(u), exp_id);
        chk("txn_match_cnt", get_cnt(u), exp_cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw;
        logic [7:0] e;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic echo transaction: 1011_0110 -> five matches, 10-cycle latency
        do_txn(0, 2'b01, {8'h00, 8'b1011_0110}, 0, 5, 10, 8'b1011_0110);

        // Continuous requests from both: rr pointer is now 1, so grants
        // alternate 1,0,1,0
        exp_q.push_back({4'd1, 4'd1});
        exp_q.push_back({4'd0, 4'd8});
        exp_q.push_back({4'd1, 4'd1});
        exp_q.push_back({4'd0, 4'd8});
        @(posedge clk); #2;
        drive(0, 2'b11, {8'h01, 8'hFF});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            saw = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (done0) begin saw = 1; break; end
            end
            chk("alt_done_seen", int'(saw), 1);
            chk("alt_done_id", int'(id0), int'(e[7:4]));
            chk("alt_match_cnt", int'(cnt0), int'(e[3:0]));
        end
        @(posedge clk); #2;
        drive(0, 2'b00, 16'h0000);
        repeat (2) @(posedge clk);

        // All-zero word: no matches
        do_txn(0, 2'b01, {8'h00, 8'h00}, 0, 0, 10, 8'h00);

        // Abort with reset during the 4th SHIFT cycle
        @(posedge clk); #2;
        drive(0, 2'b01, {8'h00, 8'hA5});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 != 2'b00) break;
        end
        @(posedge clk); #2;               // CLR cycle
        drive(0, 2'b00, 16'h0000);
        repeat (4) @(posedge clk);        // SHIFT j=3
        #2 rst = 1'b1;
        #1;
        chk("abort_detreset_immediate", int'(dr0), 1);
        chk("abort_busy_immediate", int'(busy0), 0);
        @(posedge clk); #2 rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done0) saw = 1;
        end
        chk("abort_no_done", int'(saw), 0);

        // The rr pointer is back at 0, so requester 0 wins a tie
        do_txn(0, 2'b11, {8'h3C, 8'h81}, 0, 2, 10, 8'h81);
        do_txn(0, 2'b10, {8'h3C, 8'h00}, 1, 4, 10, 8'h3C);

        // Registered detector: the DRAIN sample is counted; 11-cycle latency
        do_txn(1, 2'b10, {8'b1000_0001, 8'h00}, 1, 2, 11, 8'b1000_0001);
        // Saturation at 7 with CNTW=3
        do_txn(1, 2'b01, {8'h00, 8'hFF}, 0, 7, 11, 8'hFF);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/det_share_ctrl.md
Name: det_share_ctrl

Overview:
- Round-robin controller that shares one serial sequence-detector FSM (single-bit input X, single-bit output Z, its own reset) among NREQ requesters.
- Each requester submits a WIDTH-bit word. The controller grants one requester, clears the detector, and shifts the word in MSB first.
- It counts the cycles where the detector asserts Z and returns the count with the requester ID.
- Sits between the requester logic and the detector instance; it is the only driver of the detector's X and reset.

Parameters:
- WIDTH, 8, bits per word shifted into the detector (2..32).
- NREQ, 2, number of requesters (2..4).
- CNTW, 4, width of match counter; must satisfy 2^CNTW > WIDTH.
- LAT, 0, detector output latency: 0 = Mealy (Z valid in the same cycle as X), 1 = Moore/registered (Z valid one cycle after X).

Ports:
- Clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until granted.
- data  input  NREQ*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot, one-cycle grant pulse; data[i] is captured on that edge.
- busy  output  1  high from grant through the DONE cycle.
- det_X  output  1  serial bit to detector X.
- det_reset  output  1  detector reset (active-high).
- det_Z  input  1  detector output Z.
- done  output  1  one-cycle pulse; result valid.
- done_id  output  $clog2(NREQ)  ID of the finished requester; held until next done.
- match_cnt  output  CNTW  number of sampled det_Z=1 cycles; held until next done.

Behaviour:
- Reset values: gnt=0, busy=0, det_X=0, done=0, done_id=0, match_cnt=0, state=IDLE, rr pointer=0.
- det_reset = reset OR (state==CLR), so a controller reset also resets the detector asynchronously.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from rr pointer upward, with wrap.
  - gnt[k]=1 for that one cycle; capture data[k] into the shift register; latch k; clear the counter.
  - rr pointer <= (k+1) mod NREQ.
  - Next state CLR. With no req, stay in IDLE with gnt=0.
- CLR: one cycle with det_reset=1 and det_X=0. Next state SHIFT.
- SHIFT:
  - WIDTH cycles; cycle j drives det_X = word bit [WIDTH-1-j].
  - LAT=0: the counter increments on each SHIFT cycle with det_Z=1.
  - LAT=1: counting starts from the second SHIFT cycle, and the first sample is ignored (it reflects the reset state).
  - After the last bit: LAT=0 goes to DONE; LAT=1 goes to DRAIN.
- DRAIN (LAT=1 only): det_X=0; sample det_Z once more (the response to the last bit). Next state DONE.
- DONE:
  - done=1 for one cycle; done_id and match_cnt are updated on this edge.
  - busy=1 this cycle, and busy falls on the next edge.
  - Next state IDLE. A new grant is possible in the cycle after DONE, never in the same cycle.
- Counter saturates at 2^CNTW-1 and never wraps.
- Requests that arrive while busy are ignored until IDLE; no request queueing.
- Dropping req after grant has no effect; dropping req before grant means no grant is issued.
- Simultaneous requests are resolved purely by the rr pointer. Back-to-back requests from the same requester alternate with any other pending requester.
- Reset asserted mid-SHIFT aborts the transaction: no done, outputs return to reset values immediately, and the rr pointer returns to 0.
- Latency, grant to done: 1 (CLR) + WIDTH + LAT + 1 cycles; 10 cycles at defaults.

Optional Feature:
- Macro DET_FIRSTPOS_EN adds output first_pos (width $clog2(WIDTH)+1).
- With the macro defined:
  - first_pos holds the SHIFT index j (0-based) of the first counted det_Z=1 of the transaction.
  - The value is all-ones if there was no match.
  - It updates with done and resets to 0.
- Without the macro: the port and logic are absent, and all other behaviour is identical.

Test Plan:
- Stub det_Z = det_X (Mealy echo, LAT=0); req=2'b01, data[7:0]=8'b1011_0110 → gnt=01 pulse; det_X sequence 1,0,1,1,0,1,1,0; done 10 cycles after grant with done_id=0, match_cnt=5 (first_pos=0 if DET_FIRSTPOS_EN).
- req=2'b11 held continuously, data0=8'hFF, data1=8'h01 → grants alternate 01, 10, 01, …; results (id0,8), (id1,1) repeating; no grant during busy.
- LAT=1 with stub det_Z registered from det_X, data=8'b1000_0001 → match_cnt=2 (the DRAIN sample is counted); grant to done is 11 cycles.
- CNTW=3, WIDTH=8, data=8'hFF → match_cnt saturates at 7.
- Assert reset for 1 cycle during the 4th SHIFT cycle → det_reset high immediately; busy=0; no done pulse; next req=2'b10 is granted first (rr pointer=0 → first set bit from 0 is 1).
- data=8'h00 with echo stub → match_cnt=0; first_pos=all-ones when DET_FIRSTPOS_EN is defined.
